draw_start_lights: RTL and testbench
====================================

DRAW_START_LIGHTS -- requirements
Module: draw_start_lights

Interface
REQ-001 Parameter LAMPS, 3: number of start lamps; legal range 1..8.
REQ-002 Parameter LAMP_SIZE, 20: lamp square edge in pixels.
REQ-003 Parameter LAMP_GAP, 10: horizontal gap between adjacent lamps in pixels.
REQ-004 Parameter XPOS, 600: left x of lamp 0.
REQ-005 Parameter YPOS, 300: top y of all lamps.
REQ-006 Parameter FRAMES_PER_STEP, 60: frames per countdown step; legal range 1..1023.
REQ-007 clk  in  1  pixel clock; all state on rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 hcount_in, vcount_in  in  11 each  pixel coordinates.
REQ-010 hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing signals.
REQ-011 rgb_in  in  12  upstream pixel colour.
REQ-012 start  in  1  one-cycle pulse that begins or restarts the countdown.
REQ-013 false_start  in  1  level; player launched early.
REQ-014 hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out  out  widths as inputs  delayed timing and composed pixel.
REQ-015 go  out  1  high while in GO state.
REQ-016 fault  out  1  high while in FAULT state.
REQ-017 lamps_lit  out  4  number of amber lamps currently lit.

Function
REQ-018 All timing outputs shall equal the corresponding inputs delayed by exactly 1 clk.
REQ-019 rgb_out shall be registered with 1-clk latency, using state values as they stand in the input cycle.
REQ-020 Frame tick: a vsync_in rising edge detected against a registered copy of vsync_in, giving one tick per frame.
REQ-021 FSM states: IDLE, COUNT, GO, FAULT.
REQ-022 IDLE --start--> COUNT; lamps_lit is cleared to 0 and the 10-bit frame counter is cleared to 0.
REQ-023 COUNT, on each tick: frame counter increments.
REQ-024 When the frame counter equals FRAMES_PER_STEP-1 on a tick, it clears to 0 and one of the following occurs:
  - lamps_lit < LAMPS: lamps_lit increments.
  - lamps_lit == LAMPS: the FSM enters GO.
REQ-025 GO is therefore entered on tick number (LAMPS+1)*FRAMES_PER_STEP after start.
REQ-026 COUNT --false_start--> FAULT; false_start takes priority over a step completion in the same cycle.
REQ-027 GO and FAULT --start--> COUNT, with counters cleared; otherwise both states hold indefinitely.
REQ-028 start is ignored in COUNT; false_start is ignored in IDLE, GO and FAULT.
REQ-029 start in the same cycle as a tick: the tick is not counted.
REQ-030 start in the same cycle as false_start in IDLE, GO or FAULT: the FSM goes to COUNT.
REQ-031 Lamp k (0..LAMPS-1) region: hcount in [XPOS+k*(LAMP_SIZE+LAMP_GAP), +LAMP_SIZE-1]; vcount in [YPOS, YPOS+LAMP_SIZE-1].
REQ-032 Lamp colours by state:
  - IDLE: all lamps 12'h333.
  - COUNT: lamp k < lamps_lit is 12'hfa0; other lamps 12'h333.
  - GO: all lamps 12'h0f0.
  - FAULT: all lamps 12'hf00.
REQ-033 Housing region: hcount in [XPOS-4, last lamp right edge+4]; vcount in [YPOS-4, YPOS+LAMP_SIZE+3]. Housing pixels outside any lamp shall be 12'h222.
REQ-034 Pixel priority: blanking (hblnk_in or vblnk_in) gives 12'h000; then lamp; then housing; then rgb_in.
REQ-035 go, fault and lamps_lit shall be registered and shall reflect the current FSM state and counter.

Reset
REQ-036 On reset, all outputs go to 0 and the FSM goes to IDLE; frame counter, lamps_lit and the vsync history register go to 0.
REQ-037 Reset asserted mid-COUNT or in GO shall abort immediately to IDLE, without waiting for a clock edge.
REQ-038 After reset deasserts, the first vsync rising edge shall produce exactly one tick.

Verification (LAMPS=3, FRAMES_PER_STEP=2, XPOS=600, YPOS=300)
REQ-039 Countdown scenario: start pulse, then ticks.
  - lamps_lit reads 1, 2, 3 after ticks 2, 4, 6.
  - go=1 after tick 8.
  - Pixel (605,305) reads 12'hfa0 after tick 2 and 12'h0f0 after tick 8.
REQ-040 False-start scenario: false_start=1 after tick 3 → fault=1, pixel (665,310) reads 12'hf00; a subsequent start pulse → COUNT with lamps_lit=0.
REQ-041 Pixel-region scenario: rgb_in=12'habc with state IDLE.
  - (596,300) reads 12'h222.
  - (600,300) reads 12'h333.
  - (595,300) reads 12'habc.
  - Any pixel with hblnk_in=1 reads 12'h000.
  - All outputs appear 1 clk after their inputs.
REQ-042 Collision scenario: start and a tick in the same cycle → frame counter 0. Separately, false_start coincident with the step-8 tick → FAULT, go stays 0.
REQ-043 Mid-operation reset scenario: assert reset mid-COUNT → go=0, fault=0, lamps_lit=0, rgb_out=0 before the next clk edge; after release, state is IDLE.

Source files
------------

// File: rtl/draw_start_lights_if.sv
// Video timing bundle carried between pipeline stages: pixel coordinates,
// sync/blank strobes and the 12-bit pixel colour.
interface draw_start_lights_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport master (
        output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );

    modport slave (
        input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );
endinterface

// File: rtl/draw_start_lights.sv
// Race start-lights overlay: a frame-paced amber countdown that ends in GO or
// FAULT, drawn as a row of lamps in a dark housing over the incoming video.
module draw_start_lights #(
    parameter int LAMPS           = 3,
    parameter int LAMP_SIZE       = 20,
    parameter int LAMP_GAP        = 10,
    parameter int XPOS            = 600,
    parameter int YPOS            = 300,
    parameter int FRAMES_PER_STEP = 60
) (
    input  logic                        clk,
    input  logic                        reset,
    draw_start_lights_if.slave          vin,
    draw_start_lights_if.master         vout,
    input  logic                        start,
    input  logic                        false_start,
    output logic                        go,
    output logic                        fault,
    output logic [3:0]                  lamps_lit
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        GO    = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam int         PITCH      = LAMP_SIZE + LAMP_GAP;
    localparam logic [9:0] STEP_LAST  = 10'(FRAMES_PER_STEP - 1);
    localparam logic [3:0] LAMPS_L    = 4'(LAMPS);
    localparam int         HOUSE_X0   = XPOS - 4;
    localparam int         HOUSE_X1   = XPOS + (LAMPS - 1) * PITCH + LAMP_SIZE - 1 + 4;
    localparam int         HOUSE_Y0   = YPOS - 4;
    localparam int         HOUSE_Y1   = YPOS + LAMP_SIZE + 3;

    localparam logic [11:0] COL_OFF     = 12'h333;
    localparam logic [11:0] COL_AMBER   = 12'hfa0;
    localparam logic [11:0] COL_GO      = 12'h0f0;
    localparam logic [11:0] COL_FAULT   = 12'hf00;
    localparam logic [11:0] COL_HOUSING = 12'h222;

    state_t      r_state;
    state_t      w_nextState;
    logic [9:0]  r_frameCnt;
    logic [9:0]  w_nextFrameCnt;
    logic [3:0]  r_lampsLit;
    logic [3:0]  w_nextLampsLit;
    logic        r_vsyncPrev;
    logic        w_tick;

    int          w_hc;
    int          w_vc;
    logic        w_lampHit;
    logic        w_lampAmber;
    logic        w_housingHit;
    logic [11:0] w_lampColour;
    logic [11:0] w_pixel;

    assign w_tick = vin.vsync & ~r_vsyncPrev;

    // start wins over a same-cycle tick because the counters are simply cleared
    always_comb begin
        w_nextState    = r_state;
        w_nextFrameCnt = r_frameCnt;
        w_nextLampsLit = r_lampsLit;
        case (r_state)
            IDLE, GO, FAULT: begin
                if (start) begin
                    w_nextState    = COUNT;
                    w_nextFrameCnt = 10'd0;
                    w_nextLampsLit = 4'd0;
                end
            end
            COUNT: begin
                if (false_start) begin
                    w_nextState = FAULT;
                end else if (w_tick) begin
                    if (r_frameCnt == STEP_LAST) begin
                        w_nextFrameCnt = 10'd0;
                        if (r_lampsLit < LAMPS_L) begin
                            w_nextLampsLit = r_lampsLit + 4'd1;
                        end else begin
                            w_nextState = GO;
                        end
                    end else begin
                        w_nextFrameCnt = r_frameCnt + 10'd1;
                    end
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Status outputs are registered from next-state values so they track the FSM exactly
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_frameCnt  <= 10'd0;
            r_lampsLit  <= 4'd0;
            r_vsyncPrev <= 1'b0;
            go          <= 1'b0;
            fault       <= 1'b0;
            lamps_lit   <= 4'd0;
        end else begin
            r_state     <= w_nextState;
            r_frameCnt  <= w_nextFrameCnt;
            r_lampsLit  <= w_nextLampsLit;
            r_vsyncPrev <= vin.vsync;
            go          <= (w_nextState == GO);
            fault       <= (w_nextState == FAULT);
            lamps_lit   <= w_nextLampsLit;
        end
    end

    assign w_hc = int'(vin.hcount);
    assign w_vc = int'(vin.vcount);

    always_comb begin
        w_lampHit   = 1'b0;
        w_lampAmber = 1'b0;
        for (int k = 0; k < LAMPS; k++) begin
            if (w_hc >= XPOS + k * PITCH && w_hc <= XPOS + k * PITCH + LAMP_SIZE - 1 &&
                w_vc >= YPOS && w_vc <= YPOS + LAMP_SIZE - 1) begin
                w_lampHit   = 1'b1;
                w_lampAmber = (k < int'(r_lampsLit));
            end
        end
    end

    assign w_housingHit = (w_hc >= HOUSE_X0) && (w_hc <= HOUSE_X1) &&
                          (w_vc >= HOUSE_Y0) && (w_vc <= HOUSE_Y1);

    always_comb begin
        w_lampColour = COL_OFF;
        case (r_state)
            IDLE:    w_lampColour = COL_OFF;
            COUNT:   w_lampColour = w_lampAmber ? COL_AMBER : COL_OFF;
            GO:      w_lampColour = COL_GO;
            FAULT:   w_lampColour = COL_FAULT;
            default: w_lampColour = COL_OFF;
        endcase
    end

    always_comb begin
        w_pixel = vin.rgb;
        if (vin.hblnk || vin.vblnk) begin
            w_pixel = 12'h000;
        end else if (w_lampHit) begin
            w_pixel = w_lampColour;
        end else if (w_housingHit) begin
            w_pixel = COL_HOUSING;
        end
    end

    // One-stage video pipeline keeps timing and composed pixel aligned
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vout.hcount <= 11'd0;
            vout.vcount <= 11'd0;
            vout.hsync  <= 1'b0;
            vout.vsync  <= 1'b0;
            vout.hblnk  <= 1'b0;
            vout.vblnk  <= 1'b0;
            vout.rgb    <= 12'h000;
        end else begin
            vout.hcount <= vin.hcount;
            vout.vcount <= vin.vcount;
            vout.hsync  <= vin.hsync;
            vout.vsync  <= vin.vsync;
            vout.hblnk  <= vin.hblnk;
            vout.vblnk  <= vin.vblnk;
            vout.rgb    <= w_pixel;
        end
    end

endmodule

// File: tb/tb_draw_start_lights.sv
// Directed bench for the start-lights overlay with a fast two-frame step so
// whole countdowns fit in a few hundred cycles.
module tb_draw_start_lights;

    logic       clk;
    logic       reset;
    logic       start;
    logic       falseStart;
    logic       go;
    logic       fault;
    logic [3:0] lampsLit;

    int totalChecks;
    int badChecks;

    draw_start_lights_if vin ();
    draw_start_lights_if vout ();

    draw_start_lights #(
        .LAMPS           (3),
        .LAMP_SIZE       (20),
        .LAMP_GAP        (10),
        .XPOS            (600),
        .YPOS            (300),
        .FRAMES_PER_STEP (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .vin         (vin.slave),
        .vout        (vout.master),
        .start       (start),
        .false_start (falseStart),
        .go          (go),
        .fault       (fault),
        .lamps_lit   (lampsLit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    // Present one pixel for a single cycle; rgb_out then holds its composed colour
    task automatic applyStimulus(input int h, input int v, input logic hb);
        vin.hcount = 11'(h);
        vin.vcount = 11'(v);
        vin.hblnk  = hb;
        stepClock();
        vin.hblnk  = 1'b0;
    endtask

    task automatic frameTick();
        vin.vsync = 1'b1;
        stepClock();
        vin.vsync = 1'b0;
        stepClock();
    endtask

    task automatic pulseStart();
        start = 1'b1;
        stepClock();
        start = 1'b0;
    endtask

    initial begin
        totalChecks = 0;
        badChecks   = 0;
        reset       = 1'b1;
        start       = 1'b0;
        falseStart  = 1'b0;
        vin.hcount  = 11'd5;
        vin.vcount  = 11'd7;
        vin.hsync   = 1'b1;
        vin.vsync   = 1'b0;
        vin.hblnk   = 1'b0;
        vin.vblnk   = 1'b0;
        vin.rgb     = 12'habc;

        #22;
        checkOutput("rst_go",     32'(go),          32'd0);
        checkOutput("rst_fault",  32'(fault),       32'd0);
        checkOutput("rst_lamps",  32'(lampsLit),    32'd0);
        checkOutput("rst_rgb",    32'(vout.rgb),    32'd0);
        checkOutput("rst_hcount", 32'(vout.hcount), 32'd0);
        checkOutput("rst_hsync",  32'(vout.hsync),  32'd0);
        reset     = 1'b0;
        vin.hsync = 1'b0;
        stepClock();

        // Pixel regions and pipeline latency in IDLE
        applyStimulus(596, 300, 1'b0);
        checkOutput("pix_housing", 32'(vout.rgb), 32'h222);
        applyStimulus(600, 300, 1'b0);
        checkOutput("pix_idle_lamp", 32'(vout.rgb), 32'h333);
        applyStimulus(595, 300, 1'b0);
        checkOutput("pix_passthru", 32'(vout.rgb), 32'habc);
        applyStimulus(600, 300, 1'b1);
        checkOutput("pix_hblank", 32'(vout.rgb), 32'h000);

        vin.hcount = 11'd123;
        vin.vcount = 11'd45;
        vin.hsync  = 1'b1;
        vin.vblnk  = 1'b1;
        #1;
        checkOutput("lat_before_h", 32'(vout.hcount), 32'd600);
        checkOutput("lat_before_hs", 32'(vout.hsync), 32'd0);
        stepClock();
        checkOutput("lat_hcount", 32'(vout.hcount), 32'd123);
        checkOutput("lat_vcount", 32'(vout.vcount), 32'd45);
        checkOutput("lat_hsync",  32'(vout.hsync),  32'd1);
        checkOutput("lat_vblnk",  32'(vout.vblnk),  32'd1);
        checkOutput("lat_vblank_rgb", 32'(vout.rgb), 32'h000);
        vin.hsync = 1'b0;
        vin.vblnk = 1'b0;
        stepClock();

        falseStart = 1'b1;
        stepClock();
        falseStart = 1'b0;
        checkOutput("idle_fs_ignored", 32'(fault), 32'd0);

        // Full countdown: one amber lamp per two ticks, GO on tick eight
        pulseStart();
        checkOutput("cd_start_lamps", 32'(lampsLit), 32'd0);
        for (int n = 1; n <= 8; n++) begin
            frameTick();
            checkOutput($sformatf("cd_lamps_t%0d", n), 32'(lampsLit), 32'((n / 2 > 3) ? 3 : n / 2));
            checkOutput($sformatf("cd_go_t%0d", n), 32'(go), 32'(n == 8));
            if (n == 2) begin
                applyStimulus(605, 305, 1'b0);
                checkOutput("cd_amber0", 32'(vout.rgb), 32'hfa0);
                applyStimulus(635, 305, 1'b0);
                checkOutput("cd_dark1", 32'(vout.rgb), 32'h333);
            end
        end
        applyStimulus(605, 305, 1'b0);
        checkOutput("cd_green", 32'(vout.rgb), 32'h0f0);
        stepClock();
        checkOutput("go_holds", 32'(go), 32'd1);

        // start coincident with a tick restarts with the counter at zero
        start     = 1'b1;
        vin.vsync = 1'b1;
        stepClock();
        start     = 1'b0;
        vin.vsync = 1'b0;
        stepClock();
        checkOutput("col_go_cleared", 32'(go), 32'd0);
        checkOutput("col_lamps0", 32'(lampsLit), 32'd0);
        frameTick();
        checkOutput("col_after1", 32'(lampsLit), 32'd0);
        frameTick();
        checkOutput("col_after2", 32'(lampsLit), 32'd1);

        // False start after tick three
        frameTick();
        falseStart = 1'b1;
        stepClock();
        falseStart = 1'b0;
        checkOutput("fs_fault", 32'(fault), 32'd1);
        checkOutput("fs_go", 32'(go), 32'd0);
        checkOutput("fs_lamps_hold", 32'(lampsLit), 32'd1);
        applyStimulus(665, 310, 1'b0);
        checkOutput("fs_red", 32'(vout.rgb), 32'hf00);
        start      = 1'b1;
        falseStart = 1'b1;
        stepClock();
        start      = 1'b0;
        falseStart = 1'b0;
        checkOutput("fs_restart_fault", 32'(fault), 32'd0);
        checkOutput("fs_restart_lamps", 32'(lampsLit), 32'd0);

        // False start coincident with the eighth tick
        for (int n = 1; n <= 7; n++) frameTick();
        checkOutput("fs8_lamps", 32'(lampsLit), 32'd3);
        falseStart = 1'b1;
        vin.vsync  = 1'b1;
        stepClock();
        falseStart = 1'b0;
        vin.vsync  = 1'b0;
        stepClock();
        checkOutput("fs8_fault", 32'(fault), 32'd1);
        checkOutput("fs8_go", 32'(go), 32'd0);

        // Asynchronous reset in the middle of a countdown
        pulseStart();
        frameTick();
        frameTick();
        applyStimulus(605, 305, 1'b0);
        checkOutput("mr_pre_rgb", 32'(vout.rgb), 32'hfa0);
        checkOutput("mr_pre_lamps", 32'(lampsLit), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("mr_go", 32'(go), 32'd0);
        checkOutput("mr_fault", 32'(fault), 32'd0);
        checkOutput("mr_lamps", 32'(lampsLit), 32'd0);
        checkOutput("mr_rgb", 32'(vout.rgb), 32'd0);
        stepClock();
        reset = 1'b0;
        stepClock();
        applyStimulus(605, 305, 1'b0);
        checkOutput("mr_idle_pix", 32'(vout.rgb), 32'h333);
        pulseStart();
        frameTick();
        checkOutput("mr_tick1", 32'(lampsLit), 32'd0);
        frameTick();
        checkOutput("mr_tick2", 32'(lampsLit), 32'd1);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
